icache_line_fill: RTL
=====================

// Module: icache_line_fill
// PURPOSE
//  Refill engine below the instruction cache. Takes one cache-line request (read fill or line write)
//  and serialises it into word beats on a 32-bit memory bus with a valid/ready handshake.
//  For reads, it assembles the returned beats into a full line and returns it with a one-cycle done pulse.
//  Also counts completed line transactions for performance statistics.
// PARAMETERS
//  ADDR_W  32   byte address width
//  WORD_W  32   memory bus data width
//  LINE_W  128  cache line width; BEATS = LINE_W/WORD_W (derived, 4); LINE_W must be a multiple of WORD_W
// PORTS
//  clk_i        in   1       clock; all logic on rising edge
//  rst_i        in   1       reset; synchronous, active-high
//  req_valid_i  in   1       cache line request valid; held by the cache until res_ready_o
//  req_rw_i     in   1       0 = read fill, 1 = line write
//  req_addr_i   in   ADDR_W  line address; low log2(LINE_W/8) bits ignored (forced 0)
//  req_data_i   in   LINE_W  write line data (used only when req_rw_i=1)
//  res_ready_o  out  1       one-cycle done pulse
//  res_data_o   out  LINE_W  assembled read line; registered
//  busy_o       out  1       high in any state other than IDLE
//  bus_valid_o  out  1       beat request valid
//  bus_we_o     out  1       beat is a write
//  bus_addr_o   out  ADDR_W  beat byte address
//  bus_wdata_o  out  WORD_W  beat write data
//  bus_ready_i  in   1       memory accepts the beat; for reads, bus_rdata_i is valid in the same cycle
//  bus_rdata_i  in   WORD_W  beat read data
//  lines_o      out  32      completed line transactions (reads + writes); wraps at 2^32
// BEHAVIOUR
//  - Reset (rst_i=1 at an edge): state IDLE; every output 0, including res_data_o and lines_o;
//    beat counter 0; any partial line is discarded. Reset mid-transaction aborts with no done pulse.
//  - States: IDLE -> BEAT -> DONE -> IDLE.
//  - IDLE: at an edge with req_valid_i=1, capture rw, aligned base address, and req_data_i;
//    set beat index k=0; go to BEAT. req_valid_i is sampled only in IDLE; requests in BEAT/DONE are ignored.
//  - BEAT: drive bus_valid_o=1, bus_we_o=rw, bus_addr_o=base+k*(WORD_W/8),
//    bus_wdata_o=line[k*WORD_W +: WORD_W] (beat 0 = LSBs).
//    - All bus outputs stay stable until bus_ready_i=1; wait states are unbounded.
//    - At an edge with bus_ready_i=1 on a read, store bus_rdata_i into res_data_o[k*WORD_W +: WORD_W].
//    - On acceptance with k<BEATS-1: k increments. With k=BEATS-1: go to DONE.
//  - DONE: res_ready_o=1 and bus_valid_o=0 for exactly one cycle; lines_o increments at the exit edge; go to IDLE.
//  - res_data_o holds its value until overwritten by the next read's beats.
//    - A write transaction never modifies res_data_o.
//    - During a read fill, beats already returned are visible early; the cache consumes the line only
//      with res_ready_o.
//  - Latency with zero wait states: capture edge T0, beats accepted at T1..T4, res_ready_o high between
//    T4 and T5. Each wait cycle adds 1.
//  - Back-to-back: a request may be captured at the first IDLE edge after DONE.
//    Minimum spacing between done pulses is BEATS+2 cycles.
//  - bus_addr_o is computed modulo 2^ADDR_W; line alignment guarantees no wrap inside a line.
//  - busy_o = (state != IDLE). No combinational path from req_* to bus_* or res_* outputs;
//    all outputs are registered or decoded from state only.
// TESTING
//  1. Read fill, addr 0x0000_1234, bus_ready_i=1, rdata per beat 0x11111111, 0x22222222, 0x33333333, 0x44444444
//     -> bus_addr 0x1230, 0x1234, 0x1238, 0x123C; res_data_o=0x44444444_33333333_22222222_11111111;
//     res_ready_o high exactly 1 cycle, at T4; lines_o=1.
//  2. Same read, bus_ready_i low for 3 cycles on beat 2 -> bus_addr_o held at 0x1238 with bus_valid_o=1;
//     res_ready_o at T7; data identical.
//  3. Line write, addr 0x0000_2000, data 0xDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA
//     -> bus_we_o=1, wdata AAAAAAAA, BBBBBBBB, CCCCCCCC, DDDDDDDD at 0x2000..0x200C;
//     res_data_o unchanged from test 1; lines_o increments.
//  4. Change req_addr_i to 0x3000 while in BEAT -> ignored, beats continue the original line.
//     Two back-to-back requests -> second captured at the edge after DONE; pulses 6 cycles apart.
//  5. rst_i=1 after beat 1 of a read -> next cycle: all outputs 0, state IDLE, no res_ready_o.
//     Then a fresh read at 0xFFFF_FFF0 -> beats 0xFFFFFFF0..0xFFFFFFFC complete correctly.
//  6. Preload lines_o=0xFFFF_FFFF (force) then complete one read -> lines_o=0.

Source files
------------

// File: rtl/icache_line_fill.sv
// Instruction-cache line refill engine.
// Serialises one line request into word beats on a valid/ready memory bus.
module icache_line_fill #(
    parameter int ADDR_W = 32,
    parameter int WORD_W = 32,
    parameter int LINE_W = 128
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    input  logic              req_rw_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [LINE_W-1:0] req_data_i,
    output logic              res_ready_o,
    output logic [LINE_W-1:0] res_data_o,
    output logic              busy_o,
    output logic              bus_valid_o,
    output logic              bus_we_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [WORD_W-1:0] bus_wdata_o,
    input  logic              bus_ready_i,
    input  logic [WORD_W-1:0] bus_rdata_i,
    output logic [31:0]       lines_o
);

    localparam int BEATS = LINE_W / WORD_W;
    localparam int KW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int OFF_W = $clog2(LINE_W / 8);
    localparam int WB    = WORD_W / 8;
    localparam logic [KW-1:0] LAST = KW'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE,
        BEAT,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic              rw_q;
    logic [ADDR_W-1:0] base_q;
    logic [LINE_W-1:0] line_q;
    logic [KW-1:0]     k_q;
    logic [LINE_W-1:0] res_q;
    logic [31:0]       lines_q;
    logic              beat;
    logic              unused_addr;

    // Line offset bits are dropped on capture.
    assign unused_addr = ^req_addr_i[OFF_W-1:0];

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (req_valid_i) state_d = BEAT;
            BEAT:    if (bus_ready_i && k_q == LAST) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rw_q    <= 1'b0;
            base_q  <= '0;
            line_q  <= '0;
            k_q     <= '0;
            res_q   <= '0;
            lines_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        rw_q   <= req_rw_i;
                        base_q <= {req_addr_i[ADDR_W-1:OFF_W], OFF_W'(0)};
                        line_q <= req_data_i;
                        k_q    <= '0;
                    end
                end
                BEAT: begin
                    if (bus_ready_i) begin
                        if (!rw_q)
                            res_q[k_q*WORD_W +: WORD_W] <= bus_rdata_i;
                        if (k_q != LAST)
                            k_q <= k_q + 1'b1;
                    end
                end
                DONE:    lines_q <= lines_q + 32'd1;
                default: ;
            endcase
        end
    end

    // Bus outputs are decoded from registered state only.
    assign beat        = (state_q == BEAT);
    assign bus_valid_o = beat;
    assign bus_we_o    = beat & rw_q;
    assign bus_addr_o  = beat ? base_q + ADDR_W'(k_q) * ADDR_W'(WB)
                              : '0;
    assign bus_wdata_o = beat ? line_q[k_q*WORD_W +: WORD_W] : '0;
    assign res_ready_o = (state_q == DONE);
    assign busy_o      = (state_q != IDLE);
    assign res_data_o  = res_q;
    assign lines_o     = lines_q;

endmodule
